// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : digit_scan_ctrl
// Description : Time-multiplexed scan controller for a multi-digit 7-segment
//               display. Steps one shared seven_seg decoder across the digit
//               positions, with anti-ghost blanking at the start of each slot,
//               optional leading-zero suppression and tear-free digit updates.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_scan_ctrl #(
    parameter int CLOCK_FREQ   = 10_000,
    parameter int SCAN_HZ      = 1_000,
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 2,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              dec_digit,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_done
);

    // Cycles per digit slot; BLANK_CYCLES of them are dark, the rest lit.
    localparam int c_slot = CLOCK_FREQ / SCAN_HZ;
    localparam int c_cw   = (c_slot > 1) ? $clog2(c_slot) : 1;
    localparam int c_iw   = $clog2(NUM_DIGITS);

    localparam logic [c_cw-1:0] c_blank_last = c_cw'(BLANK_CYCLES - 1);
    localparam logic [c_cw-1:0] c_slot_last  = c_cw'(c_slot - 1);
    localparam logic [c_iw-1:0] c_idx_last   = c_iw'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_iw-1:0]         r_idx;
    logic [c_cw-1:0]         r_cnt;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_active;

    logic [3:0]              w_act_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_supp;
    logic [c_cw-1:0]         w_cnt_inc;
    logic [c_iw-1:0]         w_idx_inc;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic                    w_idx_last;

    // Per-digit nibble view of the frame-stable copy and its zero-suppression flag.
    // Digit 0 is always shown so an all-zero value still displays a single 0.
    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
            assign w_act_nib[k] = r_active[4*k +: 4];
            if (k == 0) begin : g_lsd
                assign w_supp[k] = 1'b0;
            end else begin : g_upper
                assign w_supp[k] = (LZ_BLANK != 0) &&
                                   (r_active[4*NUM_DIGITS-1:4*k] == '0);
            end
        end
    endgenerate

    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_idx_inc  = r_idx + 1'b1;
    assign w_onehot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;
    assign w_idx_last = (r_idx == c_idx_last);

    // Scan FSM: every output is registered and set on the edge entering the
    // cycle it describes; r_cnt runs 0..SLOT-1 across BLANK and SHOW of a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_active   <= '0;
            dec_digit  <= 4'd0;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            // Shadow capture is independent of scan state; a load on a
            // frame-start edge is only seen by the next frame.
            if (load) begin
                r_shadow <= digits_in;
            end
            frame_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    dig_en <= '0;
                    r_idx  <= '0;
                    r_cnt  <= '0;
                    if (enable) begin
                        r_state   <= ST_BLANK;
                        r_active  <= r_shadow;
                        dec_digit <= r_shadow[3:0];
                    end
                end

                ST_BLANK: begin
                    dig_en <= '0;
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (r_cnt == c_blank_last) begin
                            r_state    <= ST_SHOW;
                            dig_en     <= w_supp[r_idx] ? '0 : w_onehot;
                            frame_done <= (w_cnt_inc == c_slot_last) && w_idx_last;
                        end
                    end
                end

                ST_SHOW: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        dig_en  <= '0;
                    end else if (r_cnt == c_slot_last) begin
                        // Slot over: go dark and present the next digit to the
                        // decoder so it settles during the blank window.
                        r_state <= ST_BLANK;
                        r_cnt   <= '0;
                        dig_en  <= '0;
                        if (w_idx_last) begin
                            r_idx     <= '0;
                            r_active  <= r_shadow;
                            dec_digit <= r_shadow[3:0];
                        end else begin
                            r_idx     <= w_idx_inc;
                            dec_digit <= w_act_nib[w_idx_inc];
                        end
                    end else begin
                        r_cnt      <= w_cnt_inc;
                        frame_done <= (w_cnt_inc == c_slot_last) && w_idx_last;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                    r_cnt   <= '0;
                    dig_en  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_scan_ctrl
// Description : Self-checking bench for digit_scan_ctrl. A frame-position
//               reference model predicts each cycle's outputs into a
//               scoreboard queue that is drained after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_scan_ctrl;

    localparam int N     = 4;
    localparam int SLOT  = 10;
    localparam int BL    = 2;
    localparam int FRAME = N * SLOT;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        enable    = 1'b0;
    logic        load      = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  dec_digit;
    logic [3:0]  dig_en;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] dig;
        logic [3:0] dec;
        logic       fd;
        bit         dchk;
    } exp_t;

    exp_t sb [$];

    // Reference model state: running flag, position within frame, registers.
    bit          m_run    = 1'b0;
    int          m_pos    = 0;
    logic [15:0] m_shadow = 16'h0;
    logic [15:0] m_active = 16'h0;
    logic [3:0]  m_dec    = 4'h0;
    bit          m_dchk   = 1'b1;

    digit_scan_ctrl #(
        .CLOCK_FREQ  (10_000),
        .SCAN_HZ     (1_000),
        .NUM_DIGITS  (N),
        .BLANK_CYCLES(BL),
        .LZ_BLANK    (1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .digits_in (digits_in),
        .dec_digit (dec_digit),
        .dig_en    (dig_en),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model across one clock edge and produce the outputs expected after it.
    task automatic model_edge(input logic r, input logic en, input logic ld,
                              input logic [15:0] d, output exp_t e);
        logic [15:0] old_sh;
        int          slot;
        int          off;
        old_sh = m_shadow;
        if (r) begin
            m_run    = 1'b0;
            m_pos    = 0;
            m_shadow = 16'h0;
            m_active = 16'h0;
            m_dec    = 4'h0;
            m_dchk   = 1'b1;
        end else begin
            if (!en) begin
                if (m_run) m_dchk = 1'b0;
                m_run = 1'b0;
                m_pos = 0;
            end else if (!m_run) begin
                m_run    = 1'b1;
                m_pos    = 0;
                m_active = old_sh;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
                if (m_pos == 0) m_active = old_sh;
            end
            if (ld) m_shadow = d;
        end
        e.dig = 4'h0;
        e.fd  = 1'b0;
        if (m_run) begin
            slot   = m_pos / SLOT;
            off    = m_pos % SLOT;
            m_dec  = 4'((m_active >> (4 * slot)) & 16'hF);
            m_dchk = 1'b1;
            if (off >= BL && !(slot > 0 && (m_active >> (4 * slot)) == 16'h0))
                e.dig = 4'(1 << slot);
            e.fd = (m_pos == FRAME - 1);
        end
        e.dec  = m_dec;
        e.dchk = m_dchk;
    endtask

    // Drive one cycle of stimulus, queue its prediction, then compare after the edge.
    task automatic step(input logic r, input logic en, input logic ld, input logic [15:0] d);
        exp_t e;
        exp_t g;
        rst       = r;
        enable    = en;
        load      = ld;
        digits_in = d;
        model_edge(r, en, ld, d, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check_val("dig_en", 16'(dig_en), 16'(g.dig));
        check_val("frame_done", 16'(frame_done), 16'(g.fd));
        if (g.dchk) check_val("dec_digit", 16'(dec_digit), 16'(g.dec));
        check_val("onehot0", 16'($onehot0(dig_en)), 16'd1);
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 16'h0);
    endtask

    // Run enabled until the model sits at frame position p (bounded).
    task automatic seek(input int p);
        int budget;
        budget = 0;
        while (!(m_run && m_pos == p) && budget < 2 * FRAME + 2) begin
            step(1'b0, 1'b1, 1'b0, 16'h0);
            budget++;
        end
        check_val("seek_reached", 16'(m_run && m_pos == p), 16'd1);
    endtask

    initial begin
        logic [15:0] rnd;
        // Reset held with enable asserted
        repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0);

        // Basic scan of 4321
        step(1'b0, 1'b0, 1'b1, 16'h4321);
        run(2 * FRAME, 1'b1);

        // Leading-zero suppression
        step(1'b0, 1'b1, 1'b1, 16'h0075);
        run(3 * FRAME, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'h0000);
        run(2 * FRAME, 1'b1);

        // Non-BCD nibbles pass through
        step(1'b0, 1'b1, 1'b1, 16'hF0A9);
        run(2 * FRAME, 1'b1);

        // Tear-free update: mid-frame load, then load on the frame-start edge
        seek(19);
        step(1'b0, 1'b1, 1'b1, 16'h1111);
        seek(FRAME - 1);
        step(1'b0, 1'b1, 1'b1, 16'h2222);
        run(2 * FRAME, 1'b1);

        // Enable dropped during SHOW of digit 2, then re-enabled
        seek(2 * SLOT + 4);
        run(5, 1'b0);
        run(FRAME + 5, 1'b1);

        // Reset mid-frame clears shadow
        seek(15);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        run(2 * FRAME, 1'b1);

        // Random loads at random times
        for (int i = 0; i < 60; i++) begin
            rnd = 16'($urandom);
            if ($urandom_range(0, 1) == 1) rnd = rnd & 16'(16'hFFFF >> (4 * $urandom_range(1, 3)));
            step(1'b0, 1'b1, ($urandom_range(0, 7) == 0), rnd);
        end
        run(2 * FRAME, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
